// File: rtl/linear_sensor_pkg.sv
// linear_sensor_pkg
//   Shared definitions for the linear image sensor controller:
//   sequencer state encoding, configuration RAM word addresses and a
//   constant-evaluable ceil(log2) helper used to size pixel indices.
package linear_sensor_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_INTEG,
    S_FETCH_CAP,
    S_FETCH_MASK,
    S_INTEG,
    S_WAIT_SP,
    S_DATA,
    S_BLANK,
    S_DONE
  } lsc_state_e;

  localparam logic [7:0] CFG_INTEG_ADDR = 8'd1;
  localparam logic [7:0] CFG_CAP_ADDR   = 8'd2;
  localparam logic [7:0] CFG_MASK_ADDR  = 8'd7;

  // Smallest r with 2**r >= value; never returns less than 1 so that a
  // vector sized from it is always legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/lsc_pix_capture.sv
// lsc_pix_capture
//   Registers one ADC sample word per DATA cycle, zeroes the channels that
//   are disabled in ch_mask, and tags the word with its pixel index and a
//   last-of-scan flag. Output appears one cycle after the sample cycle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   sample_en       - capture adc_data_in this cycle
//   sample_idx      - pixel index of the sample being captured
//   sample_last     - sample is the final pixel of the scan
//   ch_mask         - per-channel enable, bit c gates channel c
//   adc_data_in     - NUM_CH packed samples, channel 0 in the LSBs
//   pix_valid_o, pix_data_o, pix_idx_o, pix_last_o - registered pixel word
module lsc_pix_capture
  import linear_sensor_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADC_W  = 16,
  parameter int unsigned IDX_W  = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [IDX_W-1:0]         sample_idx,
  input  logic                     sample_last,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*ADC_W-1:0]  adc_data_in,
  output logic                     pix_valid_o,
  output logic [NUM_CH*ADC_W-1:0]  pix_data_o,
  output logic [IDX_W-1:0]         pix_idx_o,
  output logic                     pix_last_o
);

  logic                    valid_q, valid_d;
  logic [NUM_CH*ADC_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    last_q, last_d;
  logic [NUM_CH*ADC_W-1:0] masked;

  always_comb begin
    masked = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_mask[c]) masked[c*ADC_W +: ADC_W] = adc_data_in[c*ADC_W +: ADC_W];
    end

    valid_d = sample_en;
    last_d  = sample_en & sample_last;
    data_d  = data_q;
    idx_d   = idx_q;
    if (sample_en) begin
      data_d = masked;
      idx_d  = sample_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign pix_valid_o = valid_q;
  assign pix_data_o  = data_q;
  assign pix_idx_o   = idx_q;
  assign pix_last_o  = last_q;

endmodule

// File: rtl/linear_sensor_ctrl.sv
// linear_sensor_ctrl
//   Timing controller for NUM_CH Hamamatsu-style linear image sensors run
//   in lockstep. On a start edge it reads integration time, scan count and
//   channel mask from the configuration RAM, then repeats
//   integrate -> wait for AD start pulse -> PIX_NUM pixel read-out -> blank
//   for the requested number of scans, and finally pulses done_o.
//   Optional feature macro: LSC_SP_TIMEOUT_EN -- when defined, waiting for
//   the AD start pulse gives up after SP_TIMEOUT cycles, sets the sticky
//   err_o and returns to idle; when undefined the wait is unbounded and
//   err_o stays 0.
// Ports:
//   clk, rst          - clock (<= 5 MHz), synchronous active-high reset
//   start_in          - rising edge starts a run (only from idle)
//   soft_reset_in     - abort a run, back to idle next cycle
//   sensor_reset_o    - sensor RESET / integration gate, one bit per sensor
//   sensor_clk_o      - sensor clock, inverted system clock
//   ad_sp_in          - AD start pulse from the channel 0 sensor
//   adc_data_in       - packed ADC samples, channel 0 in the LSBs
//   cfg_ram_rd_o/addr_o/din - config RAM port, data one cycle after address
//   pix_valid_o/data_o/idx_o/last_o - captured pixel stream
//   scan_idx_o        - 0-based scan number within the run
//   busy_o, done_o, err_o - run status
module linear_sensor_ctrl
  import linear_sensor_pkg::*;
#(
  parameter int unsigned PIX_NUM    = 512,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADC_W      = 16,
  parameter int unsigned BLANK_CYC  = 24,
  parameter int unsigned DONE_HOLD  = 33,
  parameter int unsigned SP_TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_in,
  input  logic                        soft_reset_in,
  output logic [NUM_CH-1:0]           sensor_reset_o,
  output logic                        sensor_clk_o,
  input  logic                        ad_sp_in,
  input  logic [NUM_CH*ADC_W-1:0]     adc_data_in,
  output logic                        cfg_ram_rd_o,
  output logic [7:0]                  cfg_ram_addr_o,
  input  logic [31:0]                 cfg_ram_din,
  output logic                        pix_valid_o,
  output logic [NUM_CH*ADC_W-1:0]     pix_data_o,
  output logic [clog2(PIX_NUM)-1:0]   pix_idx_o,
  output logic                        pix_last_o,
  output logic [31:0]                 scan_idx_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int unsigned IDX_W = clog2(PIX_NUM);
  localparam logic [IDX_W-1:0] PIX_LAST   = IDX_W'(PIX_NUM - 1);
  localparam logic [31:0]      BLANK_LAST = 32'(BLANK_CYC - 1);
  localparam logic [31:0]      DONE_LAST  = 32'(DONE_HOLD - 1);
`ifdef LSC_SP_TIMEOUT_EN
  localparam logic [31:0]      SP_LAST    = 32'(SP_TIMEOUT - 1);
`else
  logic unused_sp_timeout;
  assign unused_sp_timeout = (SP_TIMEOUT == 0);
`endif

  lsc_state_e         state_q, state_d;
  // Set when start_in was low last cycle; reset clears it so a start held
  // high through reset is not mistaken for an edge.
  logic               start_arm_q, start_arm_d;
  logic [31:0]        integ_q, integ_d;
  logic [31:0]        scan_cnt_q, scan_cnt_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [31:0]        scan_idx_q, scan_idx_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               rd_q, rd_d;
  logic [7:0]         addr_q, addr_d;
  logic               srst_q, srst_d;
  logic               err_q, err_d;

  logic               start_edge;
  logic               sample_en;
  logic [31:0]        integ_last;
  logic [31:0]        scan_last;

  // A zero setting behaves as one, so the "last" compare value never
  // underflows.
  assign integ_last = (integ_q == '0)    ? '0 : integ_q - 32'd1;
  assign scan_last  = (scan_cnt_q == '0) ? '0 : scan_cnt_q - 32'd1;
  assign start_edge = start_in & start_arm_q;

  always_comb begin
    state_d     = state_q;
    start_arm_d = ~start_in;
    integ_d     = integ_q;
    scan_cnt_d  = scan_cnt_q;
    mask_d      = mask_q;
    scan_idx_d  = scan_idx_q;
    cnt_d       = cnt_q + 32'd1;
    pix_cnt_d   = pix_cnt_q;
    err_d       = err_q;
    sample_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge && !soft_reset_in) begin
          state_d    = S_FETCH_INTEG;
          err_d      = 1'b0;
          scan_idx_d = '0;
          pix_cnt_d  = '0;
        end
      end
      S_FETCH_INTEG: begin
        integ_d = cfg_ram_din;
        state_d = S_FETCH_CAP;
      end
      S_FETCH_CAP: begin
        scan_cnt_d = cfg_ram_din;
        state_d    = S_FETCH_MASK;
      end
      S_FETCH_MASK: begin
        mask_d  = cfg_ram_din[NUM_CH-1:0];
        state_d = S_INTEG;
      end
      S_INTEG: begin
        if (cnt_q == integ_last) state_d = S_WAIT_SP;
      end
      S_WAIT_SP: begin
        if (ad_sp_in) begin
          state_d = S_DATA;
`ifdef LSC_SP_TIMEOUT_EN
        end else if (cnt_q == SP_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
`endif
        end
      end
      S_DATA: begin
        sample_en = 1'b1;
        pix_cnt_d = pix_cnt_q + IDX_W'(1);
        if (pix_cnt_q == PIX_LAST) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          if (scan_idx_q == scan_last) begin
            state_d = S_DONE;
          end else begin
            scan_idx_d = scan_idx_q + 32'd1;
            state_d    = S_INTEG;
          end
        end
      end
      S_DONE: begin
        if (cnt_q == DONE_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition above and suppresses the sample of
    // this cycle, so the pixel stream stops on the following cycle.
    if (soft_reset_in && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      sample_en = 1'b0;
    end

    // One shared cycle counter serves INTEG, WAIT_SP, BLANK and DONE; it
    // restarts on every state change.
    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_DATA && state_q != S_DATA) pix_cnt_d = '0;

    // Config RAM port is registered from the next state so the address is
    // already presented during the cycle the state is entered.
    rd_d   = 1'b0;
    addr_d = '0;
    case (state_d)
      S_IDLE:        begin rd_d = 1'b1; addr_d = CFG_INTEG_ADDR; end
      S_FETCH_INTEG: begin rd_d = 1'b1; addr_d = CFG_CAP_ADDR;   end
      S_FETCH_CAP:   begin rd_d = 1'b1; addr_d = CFG_MASK_ADDR;  end
      default:       begin rd_d = 1'b0; addr_d = '0;             end
    endcase

    srst_d = (state_q == S_INTEG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_arm_q <= 1'b0;
      integ_q     <= '0;
      scan_cnt_q  <= '0;
      mask_q      <= '0;
      scan_idx_q  <= '0;
      cnt_q       <= '0;
      pix_cnt_q   <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      srst_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_arm_q <= start_arm_d;
      integ_q     <= integ_d;
      scan_cnt_q  <= scan_cnt_d;
      mask_q      <= mask_d;
      scan_idx_q  <= scan_idx_d;
      cnt_q       <= cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      srst_q      <= srst_d;
      err_q       <= err_d;
    end
  end

  lsc_pix_capture #(
    .NUM_CH (NUM_CH),
    .ADC_W  (ADC_W),
    .IDX_W  (IDX_W)
  ) u_capture (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .sample_idx  (pix_cnt_q),
    .sample_last (pix_cnt_q == PIX_LAST),
    .ch_mask     (mask_q),
    .adc_data_in (adc_data_in),
    .pix_valid_o (pix_valid_o),
    .pix_data_o  (pix_data_o),
    .pix_idx_o   (pix_idx_o),
    .pix_last_o  (pix_last_o)
  );

  assign sensor_reset_o = {NUM_CH{srst_q}};
  assign sensor_clk_o   = ~clk;
  assign cfg_ram_rd_o   = rd_q;
  assign cfg_ram_addr_o = addr_q;
  assign scan_idx_o     = scan_idx_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_linear_sensor_ctrl.sv
module tb_linear_sensor_ctrl;

  localparam int PIX   = 512;
  localparam int BLANK = 24;
  localparam int HOLD  = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b1;
  logic        soft_reset_in = 1'b0;
  logic        ad_sp_in = 1'b0;
  logic [1:0]  sensor_reset_o;
  logic        sensor_clk_o;
  logic [31:0] adc_data_in;
  logic        cfg_ram_rd_o;
  logic [7:0]  cfg_ram_addr_o;
  logic [31:0] cfg_ram_din;
  logic        pix_valid_o;
  logic [31:0] pix_data_o;
  logic [8:0]  pix_idx_o;
  logic        pix_last_o;
  logic [31:0] scan_idx_o;
  logic        busy_o, done_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  linear_sensor_ctrl #(
    .PIX_NUM    (PIX),
    .NUM_CH     (2),
    .ADC_W      (16),
    .BLANK_CYC  (BLANK),
    .DONE_HOLD  (HOLD),
    .SP_TIMEOUT (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .soft_reset_in  (soft_reset_in),
    .sensor_reset_o (sensor_reset_o),
    .sensor_clk_o   (sensor_clk_o),
    .ad_sp_in       (ad_sp_in),
    .adc_data_in    (adc_data_in),
    .cfg_ram_rd_o   (cfg_ram_rd_o),
    .cfg_ram_addr_o (cfg_ram_addr_o),
    .cfg_ram_din    (cfg_ram_din),
    .pix_valid_o    (pix_valid_o),
    .pix_data_o     (pix_data_o),
    .pix_idx_o      (pix_idx_o),
    .pix_last_o     (pix_last_o),
    .scan_idx_o     (scan_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  // Free-running edge counter; ADC data is a known function of it.
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign adc_data_in = {cyc[15:0] + 16'h1234, cyc[15:0] ^ 16'h5A5A};

  // Config RAM model with one-cycle read latency.
  logic [31:0] cfg_mem [256];
  always @(posedge clk) cfg_ram_din <= cfg_mem[cfg_ram_addr_o];

  // Passive statistics, sampled on the falling edge.
  logic [1:0]  mon_mask = 2'b11;
  bit          sp_auto = 1'b1;
  bit          sp_force = 1'b0;
  bit          sp_pending = 1'b0;
  int          sp_wait = 0;
  bit          srst_prev = 1'b0;
  int          n_valid, n_last, n_done, n_rise, n_fall, n_srst_hi, n_split;
  int          n_data_err, n_idx_err, n_lastpos_err, n_scan_err;
  logic [31:0] first_valid, done_first, cur_scan;
  logic [8:0]  exp_idx;
  logic [31:0] srst_rise [8];
  logic [31:0] srst_fall [8];
  logic [31:0] last_cyc  [8];
  logic [31:0] last_scan [8];

  task automatic clear_stats();
    n_valid = 0; n_last = 0; n_done = 0; n_rise = 0; n_fall = 0;
    n_srst_hi = 0; n_split = 0; n_data_err = 0; n_idx_err = 0;
    n_lastpos_err = 0; n_scan_err = 0; exp_idx = '0; cur_scan = '0;
    first_valid = '0; done_first = '0; sp_pending = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [31:0] pc;
    logic [31:0] exp_data;
    ad_sp_in = sp_force;
    if (!rst) begin
      if (sensor_reset_o != 2'b00 && sensor_reset_o != 2'b11) n_split++;
      if (sensor_reset_o[0]) n_srst_hi++;
      if (sensor_reset_o[0] && !srst_prev) begin
        if (n_rise < 8) srst_rise[n_rise] = cyc;
        n_rise++;
      end
      if (!sensor_reset_o[0] && srst_prev) begin
        if (n_fall < 8) srst_fall[n_fall] = cyc;
        n_fall++;
        if (sp_auto) begin sp_pending = 1'b1; sp_wait = 3; end
      end
      srst_prev = sensor_reset_o[0];
      if (sp_pending) begin
        if (sp_wait == 0) begin ad_sp_in = 1'b1; sp_pending = 1'b0; end
        else sp_wait--;
      end
      if (done_o) begin
        if (n_done == 0) done_first = cyc;
        n_done++;
      end
      if (pix_valid_o) begin
        pc = cyc - 1;
        exp_data = {mon_mask[1] ? pc[15:0] + 16'h1234 : 16'h0,
                    mon_mask[0] ? pc[15:0] ^ 16'h5A5A : 16'h0};
        if (n_valid == 0) first_valid = cyc;
        if (pix_data_o !== exp_data) n_data_err++;
        if (pix_idx_o !== exp_idx) n_idx_err++;
        if (pix_last_o !== (pix_idx_o == 9'd511)) n_lastpos_err++;
        if (pix_idx_o == 9'd0) cur_scan = scan_idx_o;
        else if (scan_idx_o !== cur_scan) n_scan_err++;
        exp_idx = pix_last_o ? 9'd0 : pix_idx_o + 9'd1;
        if (pix_last_o) begin
          if (n_last < 8) begin last_cyc[n_last] = cyc; last_scan[n_last] = scan_idx_o; end
          n_last++;
        end
        n_valid++;
      end
    end
  end

  task automatic set_cfg(input logic [31:0] integ, input logic [31:0] cap, input logic [31:0] mask);
    cfg_mem[1] = integ;
    cfg_mem[2] = cap;
    cfg_mem[7] = mask;
    mon_mask   = mask[1:0];
  endtask

  // Returns with start_cyc = label of the edge that sampled the start edge.
  task automatic pulse_start(output logic [31:0] start_cyc);
    @(negedge clk) start_in = 1'b1;
    @(negedge clk) start_in = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy_o) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic wait_pixel(input logic [8:0] idx, input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (pix_valid_o && pix_idx_o == idx) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if ({sensor_reset_o, pix_valid_o, pix_last_o, busy_o, done_o, err_o, cfg_ram_rd_o} !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %b want 00000000", {sensor_reset_o, pix_valid_o, pix_last_o, busy_o, done_o, err_o, cfg_ram_rd_o}); end
    n_tests++; if (cfg_ram_addr_o !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", cfg_ram_addr_o); end
    n_tests++; if ({pix_data_o, pix_idx_o, scan_idx_o} !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%0d/%0d want 0", pix_data_o, pix_idx_o, scan_idx_o); end
    n_tests++; if (sensor_clk_o !== ~clk) begin n_fail++; $display("FAIL sensor_clk: got %b want %b", sensor_clk_o, ~clk); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL start_held_thru_reset: busy got %b want 0", busy_o); end
    n_tests++; if ({cfg_ram_rd_o, cfg_ram_addr_o} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL idle_cfg_port: got rd=%b addr=%0d want rd=1 addr=1", cfg_ram_rd_o, cfg_ram_addr_o); end
    start_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_scan();
    logic [31:0] sc;
    bit to;
    set_cfg(32'd10, 32'd1, 32'd3);
    clear_stats();
    pulse_start(sc);
    wait_idle(3000, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL single_timeout: got busy want idle"); end
    n_tests++; if (srst_rise[0] - sc !== 32'd4) begin n_fail++; $display("FAIL single_srst_start: got %0d want 4", srst_rise[0] - sc); end
    n_tests++; if (n_srst_hi !== 10 || n_rise !== 1 || n_split !== 0) begin n_fail++; $display("FAIL single_srst_len: got %0d/%0d/%0d want 10/1/0", n_srst_hi, n_rise, n_split); end
    n_tests++; if (first_valid - srst_fall[0] !== 32'd5) begin n_fail++; $display("FAIL single_first_pix: got %0d want 5", first_valid - srst_fall[0]); end
    n_tests++; if (n_valid !== PIX || n_last !== 1) begin n_fail++; $display("FAIL single_count: got %0d/%0d want 512/1", n_valid, n_last); end
    n_tests++; if (n_idx_err !== 0 || n_lastpos_err !== 0 || n_data_err !== 0) begin n_fail++; $display("FAIL single_pixels: got idx=%0d last=%0d data=%0d errs want 0", n_idx_err, n_lastpos_err, n_data_err); end
    n_tests++; if (n_done !== HOLD) begin n_fail++; $display("FAIL single_done_len: got %0d want %0d", n_done, HOLD); end
    n_tests++; if (done_first - last_cyc[0] !== 32'(BLANK)) begin n_fail++; $display("FAIL single_blank: got %0d want %0d", done_first - last_cyc[0], BLANK); end
  endtask

  task automatic test_multi_scan();
    logic [31:0] sc;
    bit to;
    set_cfg(32'd5, 32'd3, 32'd1);
    clear_stats();
    pulse_start(sc);
    wait_idle(5000, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL multi_timeout: got busy want idle"); end
    n_tests++; if (n_valid !== 3*PIX || n_last !== 3) begin n_fail++; $display("FAIL multi_count: got %0d/%0d want 1536/3", n_valid, n_last); end
    n_tests++; if (last_scan[0] !== 0 || last_scan[1] !== 1 || last_scan[2] !== 2 || n_scan_err !== 0) begin n_fail++; $display("FAIL multi_scan_idx: got %0d,%0d,%0d err=%0d want 0,1,2 err=0", last_scan[0], last_scan[1], last_scan[2], n_scan_err); end
    n_tests++; if (n_data_err !== 0 || n_idx_err !== 0) begin n_fail++; $display("FAIL multi_mask_data: got data=%0d idx=%0d errs want 0", n_data_err, n_idx_err); end
    n_tests++; if (srst_rise[1] - last_cyc[0] !== 32'(BLANK+1) || srst_rise[2] - last_cyc[1] !== 32'(BLANK+1)) begin n_fail++; $display("FAIL multi_gaps: got %0d,%0d want %0d", srst_rise[1] - last_cyc[0], srst_rise[2] - last_cyc[1], BLANK+1); end
    n_tests++; if (done_first - last_cyc[2] !== 32'(BLANK) || n_done !== HOLD) begin n_fail++; $display("FAIL multi_done: got gap=%0d len=%0d want %0d/%0d", done_first - last_cyc[2], n_done, BLANK, HOLD); end
  endtask

  task automatic test_zero_cfg();
    logic [31:0] sc;
    bit to;
    set_cfg(32'd0, 32'd0, 32'd3);
    clear_stats();
    pulse_start(sc);
    wait_idle(3000, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL zero_timeout: got busy want idle"); end
    n_tests++; if (n_srst_hi !== 1 || n_rise !== 1) begin n_fail++; $display("FAIL zero_integ: got %0d/%0d want 1/1", n_srst_hi, n_rise); end
    n_tests++; if (n_valid !== PIX || n_last !== 1 || n_done !== HOLD) begin n_fail++; $display("FAIL zero_scan: got %0d/%0d/%0d want 512/1/33", n_valid, n_last, n_done); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] sc;
    bit to;
    set_cfg(32'd8, 32'd2, 32'd3);
    clear_stats();
    pulse_start(sc);
    wait_pixel(9'd100, 2000, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL abort_reach_pix: got no pixel 100 want pixel 100"); end
    soft_reset_in = 1'b1;
    @(negedge clk) soft_reset_in = 1'b0;
    n_tests++; if ({pix_valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL abort_stop: got valid=%b busy=%b want 0/0", pix_valid_o, busy_o); end
    repeat (60) @(negedge clk);
    n_tests++; if (n_done !== 0 || n_valid !== 101) begin n_fail++; $display("FAIL abort_no_done: got done=%0d pix=%0d want 0/101", n_done, n_valid); end
    set_cfg(32'd4, 32'd1, 32'd2);
    clear_stats();
    pulse_start(sc);
    wait_idle(3000, to);
    n_tests++; if (to || n_valid !== PIX || n_done !== HOLD || n_data_err !== 0) begin n_fail++; $display("FAIL abort_rerun: got to=%0d pix=%0d done=%0d derr=%0d want 0/512/33/0", to, n_valid, n_done, n_data_err); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] sc;
    logic [31:0] sc2;
    bit to;
    set_cfg(32'd6, 32'd1, 32'd3);
    clear_stats();
    pulse_start(sc);
    wait_pixel(9'd50, 2000, to);
    pulse_start(sc2);
    wait_idle(3000, to);
    repeat (20) @(negedge clk);
    n_tests++; if (to || busy_o !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got to=%0d busy=%b want 0/0", to, busy_o); end
    n_tests++; if (n_valid !== PIX || n_rise !== 1 || n_done !== HOLD) begin n_fail++; $display("FAIL ign_data_start: got pix=%0d integ=%0d done=%0d want 512/1/33", n_valid, n_rise, n_done); end
    @(negedge clk) begin start_in = 1'b1; soft_reset_in = 1'b1; end
    @(negedge clk) begin start_in = 1'b0; soft_reset_in = 1'b0; end
    repeat (3) @(negedge clk);
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ign_soft_start: got busy=%b want 0", busy_o); end
  endtask

  task automatic test_sp_timeout();
    logic [31:0] sc;
    logic [31:0] err_cyc;
    bit to;
    set_cfg(32'd4, 32'd1, 32'd3);
    clear_stats();
    sp_auto = 1'b0;
    pulse_start(sc);
`ifdef LSC_SP_TIMEOUT_EN
    to = 1'b1;
    err_cyc = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err_o) begin err_cyc = cyc; to = 1'b0; break; end
    end
    n_tests++; if (to) begin n_fail++; $display("FAIL to_err_set: got err=0 want 1"); end
    n_tests++; if (err_cyc - srst_fall[0] !== 32'd63) begin n_fail++; $display("FAIL to_err_time: got %0d want 63", err_cyc - srst_fall[0]); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL to_idle: got busy=%b want 0", busy_o); end
    repeat (40) @(negedge clk);
    n_tests++; if (err_o !== 1'b1 || n_done !== 0 || n_valid !== 0) begin n_fail++; $display("FAIL to_sticky: got err=%b done=%0d pix=%0d want 1/0/0", err_o, n_done, n_valid); end
    sp_auto = 1'b1;
    clear_stats();
    pulse_start(sc);
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b want 0", err_o); end
    wait_idle(3000, to);
    n_tests++; if (to || n_valid !== PIX || n_done !== HOLD || err_o !== 1'b0) begin n_fail++; $display("FAIL to_rerun: got to=%0d pix=%0d done=%0d err=%b want 0/512/33/0", to, n_valid, n_done, err_o); end
`else
    err_cyc = '0;
    repeat (150) @(negedge clk);
    n_tests++; if ({err_o, busy_o, pix_valid_o} !== 3'b010) begin n_fail++; $display("FAIL sp_wait_forever: got err=%b busy=%b valid=%b want 0/1/0", err_o, busy_o, pix_valid_o); end
    sp_force = 1'b1;
    wait_idle(3000, to);
    sp_force = 1'b0;
    sp_auto = 1'b1;
    n_tests++; if (to || n_valid !== PIX || n_done !== HOLD || err_o !== 1'b0 || err_cyc !== '0) begin n_fail++; $display("FAIL sp_late_run: got to=%0d pix=%0d done=%0d err=%b want 0/512/33/0", to, n_valid, n_done, err_o); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) cfg_mem[i] = 32'h0000_FFFF;
    clear_stats();
    test_reset();
    test_single_scan();
    test_multi_scan();
    test_zero_cfg();
    test_soft_reset();
    test_start_ignored();
    test_sp_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish by cycle 60000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
